// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between the data cache and instruction fetch.
// Tracks which requester owns each in-flight load tag so returning data is routed.

`ifndef NUM_MEM_TAGS
`define NUM_MEM_TAGS 15
`endif

module mem_arbiter #(
  parameter int unsigned NUM_MEM_TAGS = `NUM_MEM_TAGS,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned BLOCK_W      = 64,
  localparam int unsigned TAG_W       = $clog2(NUM_MEM_TAGS + 1),
  localparam int unsigned CMD_W       = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               dc_req,
  input  logic [CMD_W-1:0]   dc_command,
  input  logic [ADDR_W-1:0]  dc_addr,
  input  logic [BLOCK_W-1:0] dc_data,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic [TAG_W-1:0]   mem_transaction_tag,
  input  logic [TAG_W-1:0]   mem_data_tag,
  input  logic [BLOCK_W-1:0] mem_data,
  output logic [CMD_W-1:0]   proc2mem_command,
  output logic [ADDR_W-1:0]  proc2mem_addr,
  output logic [BLOCK_W-1:0] proc2mem_data,
  output logic               if_grant,
  output logic               dc_grant,
  output logic [TAG_W-1:0]   if_transaction_tag,
  output logic [TAG_W-1:0]   dc_transaction_tag,
  output logic [TAG_W-1:0]   if_data_tag,
  output logic [TAG_W-1:0]   dc_data_tag,
  output logic [BLOCK_W-1:0] if_data,
  output logic [BLOCK_W-1:0] dc_data_out,
  output logic               tag_error
);

  // Command encoding shared with memory: 0 none, 1 load, 2 store.
  localparam logic [CMD_W-1:0] MEM_NONE = CMD_W'(0);
  localparam logic [CMD_W-1:0] MEM_LOAD = CMD_W'(1);

  localparam int unsigned CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]        starve_cnt_q, starve_cnt_d;
  logic [NUM_MEM_TAGS:1]   owner_valid_q, owner_valid_d;
  logic [NUM_MEM_TAGS:1]   owner_is_dc_q, owner_is_dc_d;
  logic                    tag_error_q, tag_error_d;

  logic                    starved;
  logic                    trans_tag_nz;
  logic                    data_tag_nz;
  logic                    if_accept;
  logic                    dc_accept;
  logic                    load_accept;
  logic [NUM_MEM_TAGS:1]   alloc_sel;
  logic [NUM_MEM_TAGS:1]   ret_sel;
  logic [NUM_MEM_TAGS:1]   ret_hit_vec;
  logic                    ret_hit;
  logic                    ret_to_dc;

  // Grant never depends on if_req so fetch logic can use it without a loop.
  assign starved      = (starve_cnt_q == CNT_MAX);
  assign if_grant     = ~dc_req | starved;
  assign dc_grant     = dc_req & ~starved;

  assign trans_tag_nz = (mem_transaction_tag != '0);
  assign data_tag_nz  = (mem_data_tag != '0);
  assign if_accept    = if_grant & if_req & trans_tag_nz;
  assign dc_accept    = dc_grant & trans_tag_nz;
  assign load_accept  = if_accept | (dc_accept & (dc_command == MEM_LOAD));

  // Per-tag decode of the accepted tag and the returning tag.
  for (genvar g = 1; g <= NUM_MEM_TAGS; g++) begin : g_tag_dec
    assign alloc_sel[g] = load_accept & (mem_transaction_tag == TAG_W'(g));
    assign ret_sel[g]   = (mem_data_tag == TAG_W'(g));
  end

  assign ret_hit_vec = ret_sel & owner_valid_q;
  assign ret_hit     = |ret_hit_vec;
  assign ret_to_dc   = |(ret_hit_vec & owner_is_dc_q);

  // Memory command mux.
  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (dc_grant) begin
      proc2mem_command = dc_command;
      proc2mem_addr    = dc_addr;
      proc2mem_data    = dc_data;
    end else if (if_grant && if_req) begin
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = if_addr;
    end
  end

  assign if_transaction_tag = if_grant ? mem_transaction_tag : '0;
  assign dc_transaction_tag = dc_grant ? mem_transaction_tag : '0;
  assign if_data_tag        = (ret_hit && !ret_to_dc) ? mem_data_tag : '0;
  assign dc_data_tag        = (ret_hit && ret_to_dc) ? mem_data_tag : '0;
  assign if_data            = mem_data;
  assign dc_data_out        = mem_data;
  assign tag_error          = tag_error_q;

  // Next state: starvation counter, owner table, sticky error.
  always_comb begin
    starve_cnt_d  = starve_cnt_q;
    owner_valid_d = owner_valid_q;
    owner_is_dc_d = owner_is_dc_q;
    tag_error_d   = tag_error_q;

    if (if_req && !if_accept) begin
      starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
    end else if (if_grant) begin
      starve_cnt_d = '0;
    end

    // Allocation is applied after the return clear so it wins on a tag collision.
    owner_valid_d = (owner_valid_q & ~ret_sel) | alloc_sel;
    owner_is_dc_d = (owner_is_dc_q & ~alloc_sel) | (alloc_sel & {NUM_MEM_TAGS{dc_grant}});

    if (data_tag_nz && !ret_hit) begin
      tag_error_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt_q  <= '0;
      owner_valid_q <= '0;
      owner_is_dc_q <= '0;
      tag_error_q   <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      owner_valid_q <= owner_valid_d;
      owner_is_dc_q <= owner_is_dc_d;
      tag_error_q   <= tag_error_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a tag-ownership model checked every cycle plus directed scenarios.

module tb_mem_arbiter;

  localparam int unsigned NTAGS  = 15;
  localparam int unsigned LIMIT  = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned BW     = 64;
  localparam int unsigned TW     = 4;
  localparam logic [1:0]  C_NONE  = 2'd0;
  localparam logic [1:0]  C_LOAD  = 2'd1;
  localparam logic [1:0]  C_STORE = 2'd2;

  logic          clk = 1'b0;
  logic          reset;
  logic          dc_req;
  logic [1:0]    dc_command;
  logic [AW-1:0] dc_addr;
  logic [BW-1:0] dc_data;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [TW-1:0] mem_transaction_tag;
  logic [TW-1:0] mem_data_tag;
  logic [BW-1:0] mem_data;
  logic [1:0]    proc2mem_command;
  logic [AW-1:0] proc2mem_addr;
  logic [BW-1:0] proc2mem_data;
  logic          if_grant, dc_grant;
  logic [TW-1:0] if_transaction_tag, dc_transaction_tag;
  logic [TW-1:0] if_data_tag, dc_data_tag;
  logic [BW-1:0] if_data, dc_data_out;
  logic          tag_error;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: owner per tag (0 none, 1 fetch, 2 dcache), starve count, sticky error.
  int m_owner [0:15];
  int m_starve;
  bit m_err;

  mem_arbiter #(.NUM_MEM_TAGS(NTAGS), .STARVE_LIMIT(LIMIT), .ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clock(clk), .reset(reset),
    .dc_req(dc_req), .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
    .if_req(if_req), .if_addr(if_addr),
    .mem_transaction_tag(mem_transaction_tag), .mem_data_tag(mem_data_tag), .mem_data(mem_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .if_grant(if_grant), .dc_grant(dc_grant),
    .if_transaction_tag(if_transaction_tag), .dc_transaction_tag(dc_transaction_tag),
    .if_data_tag(if_data_tag), .dc_data_tag(dc_data_tag),
    .if_data(if_data), .dc_data_out(dc_data_out), .tag_error(tag_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, then advance the model one clock.
  always @(negedge clk) begin : cmp
    bit starved_e, ig, dg, facc, acc, is_load;
    logic [1:0]    ecmd;
    logic [AW-1:0] eaddr;
    logic [BW-1:0] edata;
    int own, t, tt;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_owner[i] = 0;
      m_starve = 0;
      m_err    = 1'b0;
    end
    starved_e = (m_starve == LIMIT);
    ig = !dc_req || starved_e;
    dg = dc_req && !starved_e;
    ecmd = C_NONE; eaddr = '0; edata = '0;
    if (dg) begin
      ecmd = dc_command; eaddr = dc_addr; edata = dc_data;
    end else if (ig && if_req) begin
      ecmd = C_LOAD; eaddr = if_addr;
    end
    t   = int'(mem_data_tag);
    tt  = int'(mem_transaction_tag);
    own = (t != 0 && t <= NTAGS) ? m_owner[t] : 0;
    chk("if_grant", if_grant, ig);
    chk("dc_grant", dc_grant, dg);
    chk("cmd", proc2mem_command, ecmd);
    chk("addr", proc2mem_addr, eaddr);
    chk("data", proc2mem_data, edata);
    chk("if_ttag", if_transaction_tag, ig ? mem_transaction_tag : 4'd0);
    chk("dc_ttag", dc_transaction_tag, dg ? mem_transaction_tag : 4'd0);
    chk("if_dtag", if_data_tag, (own == 1) ? mem_data_tag : 4'd0);
    chk("dc_dtag", dc_data_tag, (own == 2) ? mem_data_tag : 4'd0);
    chk("if_data", if_data, mem_data);
    chk("dc_data_out", dc_data_out, mem_data);
    chk("tag_error", tag_error, m_err);
    if (!reset) begin
      facc    = ig && if_req && tt != 0;
      acc     = tt != 0 && (dg || (ig && if_req));
      is_load = dg ? (dc_command == C_LOAD) : 1'b1;
      if (own != 0) m_owner[t] = 0;
      else if (t != 0) m_err = 1'b1;
      if (acc && is_load && tt <= NTAGS) m_owner[tt] = dg ? 2 : 1;
      if (if_req && !facc) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else if (ig) m_starve = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dc_req = 0; dc_command = C_NONE; dc_addr = '0; dc_data = '0;
    if_req = 0; if_addr = '0; mem_transaction_tag = '0; mem_data_tag = '0;
    mem_data = 64'hDEAD_BEEF_0000_0000 + 64'($time);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    @(negedge clk);
    chk("rst_if_grant", if_grant, 1);
    chk("rst_dc_grant", dc_grant, 0);
    chk("rst_tag_error", tag_error, 0);
    tick();
    reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle();
    tick();
    do_reset();

    // Fetch load with tag 3, then its return.
    if_req = 1; if_addr = 32'h100; mem_transaction_tag = 4'd3;
    @(negedge clk);
    chk("s1_if_grant", if_grant, 1);
    chk("s1_cmd", proc2mem_command, C_LOAD);
    chk("s1_addr", proc2mem_addr, 32'h100);
    chk("s1_if_ttag", if_transaction_tag, 3);
    tick(); idle();
    chk("s1_model_own3", m_owner[3], 1);
    tick(); mem_data_tag = 4'd3; mem_data = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    chk("s1_if_dtag", if_data_tag, 3);
    chk("s1_dc_dtag", dc_data_tag, 0);
    chk("s1_if_data", if_data, 64'h1234_5678_9ABC_DEF0);
    tick(); idle();
    chk("s1_model_own3_clr", m_owner[3], 0);

    // Continuous contention: fetch forced through on the fifth cycle.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      dc_req = 1; dc_command = C_LOAD; dc_addr = 32'h200 + 32'(c); dc_data = 64'(c);
      if_req = 1; if_addr = 32'h300; mem_transaction_tag = 4'(c + 1);
      @(negedge clk);
      chk("s2_dc_grant", dc_grant, (c != 4));
      chk("s2_if_grant", if_grant, (c == 4));
      if (c == 4) chk("s2_addr", proc2mem_addr, 32'h300);
      tick();
      if (c == 4) chk("s2_model_starve", m_starve, 0);
    end
    idle();
    mem_data_tag = 4'd5;
    @(negedge clk);
    chk("s2_if_dtag5", if_data_tag, 5);
    tick(); mem_data_tag = 4'd1;
    @(negedge clk);
    chk("s2_dc_dtag1", dc_data_tag, 1);
    tick(); mem_data_tag = 4'd6;
    @(negedge clk);
    chk("s2_dc_dtag6", dc_data_tag, 6);
    tick(); idle();

    // Accepted store allocates nothing; its tag coming back is an error.
    do_reset();
    dc_req = 1; dc_command = C_STORE; dc_addr = 32'h40; dc_data = 64'hABCD; mem_transaction_tag = 4'd5;
    @(negedge clk);
    chk("s3_cmd", proc2mem_command, C_STORE);
    chk("s3_data", proc2mem_data, 64'hABCD);
    tick(); idle(); mem_data_tag = 4'd5;
    @(negedge clk);
    chk("s3_if_dtag", if_data_tag, 0);
    chk("s3_dc_dtag", dc_data_tag, 0);
    tick(); idle();
    @(negedge clk);
    chk("s3_tag_error", tag_error, 1);
    tick();

    // Same-cycle return to fetch and reallocation of tag 7 to dcache.
    do_reset();
    if_req = 1; if_addr = 32'h700; mem_transaction_tag = 4'd7;
    tick(); idle();
    dc_req = 1; dc_command = C_LOAD; dc_addr = 32'h770; mem_transaction_tag = 4'd7; mem_data_tag = 4'd7;
    @(negedge clk);
    chk("s4_if_dtag", if_data_tag, 7);
    chk("s4_dc_dtag", dc_data_tag, 0);
    tick(); idle(); mem_data_tag = 4'd7;
    @(negedge clk);
    chk("s4_dc_dtag_after", dc_data_tag, 7);
    chk("s4_tag_error", tag_error, 0);
    tick(); idle();

    // Rejected fetch accumulates starvation; dcache then wins only twice.
    do_reset();
    if_req = 1; if_addr = 32'h880; mem_transaction_tag = 4'd0;
    tick(); tick();
    chk("s5_model_starve", m_starve, 2);
    dc_req = 1; dc_command = C_LOAD; dc_addr = 32'h990;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("s5_dc_grant", dc_grant, (c < 2));
      chk("s5_if_grant", if_grant, (c == 2));
      tick();
    end
    idle();

    // Starved cycle denies dcache even without a fetch request.
    do_reset();
    for (int c = 0; c < 6; c++) begin
      dc_req = 1; dc_command = C_STORE; dc_addr = 32'hA00; dc_data = 64'h55;
      if_req = (c != 4); if_addr = 32'hB00; mem_transaction_tag = 4'd0;
      @(negedge clk);
      chk("s6_dc_grant", dc_grant, (c != 4));
      if (c == 4) chk("s6_cmd_none", proc2mem_command, C_NONE);
      tick();
    end
    idle();

    // Reset with tags 2 and 9 in flight.
    do_reset();
    if_req = 1; if_addr = 32'hC00; mem_transaction_tag = 4'd2;
    tick(); idle();
    dc_req = 1; dc_command = C_LOAD; dc_addr = 32'hD00; mem_transaction_tag = 4'd9;
    tick(); idle();
    chk("s7_model_own2", m_owner[2], 1);
    chk("s7_model_own9", m_owner[9], 2);
    #1 reset = 1;
    #1 mem_data_tag = 4'd9;
    #1;
    chk("s7_rst_dc_dtag", dc_data_tag, 0);
    chk("s7_rst_if_dtag", if_data_tag, 0);
    mem_data_tag = 4'd0;
    tick();
    reset = 0;
    mem_data_tag = 4'd9;
    @(negedge clk);
    chk("s7_dc_dtag", dc_data_tag, 0);
    chk("s7_if_dtag", if_data_tag, 0);
    tick(); idle();
    @(negedge clk);
    chk("s7_tag_error", tag_error, 1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_MEM_TAGS, default `NUM_MEM_TAGS, is the number of nonzero memory tags (1..NUM_MEM_TAGS); tag 0 = none.
REQ-002 Parameter STARVE_LIMIT, default 4, is the consecutive denied fetch cycles before fetch is forced priority.
REQ-003 clock  in  1  system clock, all state on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 dc_req  in  1  data cache requests memory this cycle.
REQ-006 dc_command  in  MEM_COMMAND  MEM_LOAD or MEM_STORE.
REQ-007 dc_addr  in  ADDR  data cache request address.
REQ-008 dc_data  in  MEM_BLOCK  store data.
REQ-009 if_req  in  1  fetch requests a load (fetch mem_en).
REQ-010 if_addr  in  ADDR  fetch request address.
REQ-011 mem_transaction_tag  in  MEM_TAG  memory acceptance tag for the current command, 0 = rejected.
REQ-012 mem_data_tag  in  MEM_TAG  tag of returning load data, 0 = none.
REQ-013 mem_data  in  MEM_BLOCK  returning load data.
REQ-014 proc2mem_command  out  MEM_COMMAND  command to memory.
REQ-015 proc2mem_addr  out  ADDR  address to memory.
REQ-016 proc2mem_data  out  MEM_BLOCK  store data to memory.
REQ-017 if_grant  out  1  fetch may use memory this cycle (drives fetch arbiter_signal).
REQ-018 dc_grant  out  1  data cache owns memory this cycle.
REQ-019 if_transaction_tag / dc_transaction_tag  out  MEM_TAG  each  mem_transaction_tag forwarded to the granted requester, 0 to the other.
REQ-020 if_data_tag / dc_data_tag  out  MEM_TAG  each  mem_data_tag routed to the tag owner, 0 to the other.
REQ-021 if_data / dc_data_out  out  MEM_BLOCK  each  mem_data broadcast to both.
REQ-022 tag_error  out  1  sticky: a nonzero mem_data_tag arrived with no owner entry.

Function
REQ-023 if_grant SHALL be combinational from registered state and dc_req only, never from if_req (no loop through fetch): if_grant = ~dc_req | starved.
REQ-024 dc_grant SHALL equal dc_req & ~starved; if_grant and dc_grant never both 1.
REQ-025 starved SHALL be 1 when starve_cnt == STARVE_LIMIT; during a starved cycle dc is denied even if if_req = 0.
REQ-026 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle if_req = 1 and fetch not accepted; SHALL clear to 0 on a cycle with if_grant = 1 and (if_req = 0 or fetch accepted).
REQ-027 Accepted = granted requester asserting req and mem_transaction_tag != 0; a tag of 0 is a rejection, requester retries, no state recorded.
REQ-028 proc2mem_command/addr/data SHALL carry dc inputs when dc_grant, MEM_LOAD + if_addr when if_grant & if_req, else MEM_NONE, address and data 0.
REQ-029 Ownership table: owner_valid[NUM_MEM_TAGS:1], owner_is_dc[NUM_MEM_TAGS:1]; on an accepted load, entry [mem_transaction_tag] is set next edge with the winner's identity; accepted stores allocate no entry.
REQ-030 Return: if mem_data_tag != 0 and owner_valid set, tag routes same cycle to the owner's data_tag output; entry clears next edge.
REQ-031 Same-cycle return of tag T and allocation of tag T: allocation wins, entry valid with new owner.
REQ-032 Return with no owner entry: both data_tag outputs 0, tag_error set next edge, held until reset.
REQ-033 Allocation onto an already-valid entry overwrites it (memory guarantees tag uniqueness); no error.

Reset
REQ-034 reset SHALL asynchronously clear starve_cnt, owner_valid, owner_is_dc and tag_error; combinational outputs then read: if_grant = ~dc_req, dc_grant = dc_req, all tags 0 unless forwarded from memory inputs.
REQ-035 Tags in flight at reset SHALL be ignored afterward (returns flag tag_error, are not routed).

Verification
REQ-036 dc_req=0, if_req=1, if_addr=0x100, transaction_tag=3 -> if_grant=1, proc2mem MEM_LOAD 0x100, if_transaction_tag=3; later data_tag=3 -> if_data_tag=3, dc_data_tag=0, entry 3 cleared.
REQ-037 dc_req=if_req=1 continuously with tags accepted, STARVE_LIMIT=4 -> dc granted cycles 0-3, cycle 4 if_grant=1, dc_grant=0, starve_cnt returns to 0.
REQ-038 dc MEM_STORE accepted with tag 5, then data_tag=5 -> no routing, tag_error=1.
REQ-039 Load accepted with tag 7 for dc while data_tag=7 returns for fetch same cycle -> if_data_tag=7 that cycle, entry 7 valid owner dc afterward.
REQ-040 if_req=1, transaction_tag=0 for 2 cycles -> no entry allocated, starve_cnt=2.
REQ-041 Reset asserted with entries 2 and 9 valid -> table empty immediately; data_tag=9 afterward -> both data_tag outputs 0, tag_error=1.
